// File: rtl/sequence_generator.sv
// sequence_generator: transmit side of the update/value serial bit interface.
// A parallel word accepted on start is sent MSB-first on value, one bit per
// update pulse; the receiver samples value on the falling edge of update.
// All state advances on the FALLING edge of clk; reset is async, active low.
// Optional abort support is compiled in with `define SEQ_GEN_ABORT_EN.
module sequence_generator #(
    parameter int WIDTH        = 8,
    parameter int SETUP_CYCLES = 1,
    parameter int HIGH_CYCLES  = 2,
    parameter int LOW_CYCLES   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
`ifdef SEQ_GEN_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             busy,
    output logic             done,
    output logic             update,
    output logic             value
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;

    localparam int MAX_CYC =
        (SETUP_CYCLES > HIGH_CYCLES)
            ? ((SETUP_CYCLES > LOW_CYCLES) ? SETUP_CYCLES : LOW_CYCLES)
            : ((HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES);
    // Counter holds "cycles remaining minus one", so MAX_CYC-1 is its top value.
    localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] HIGH_LD  = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] LOW_LD   = CW'(LOW_CYCLES - 1);
    localparam logic [BW-1:0] BITS_LD  = BW'(WIDTH);
    localparam logic [BW-1:0] BITS_ONE = BW'(1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bits_q, bits_d;
    logic [WIDTH-1:0] sreg_q, sreg_d, shifted;
    logic             value_q, value_d;
    logic             done_q, done_d;
    logic             update_q, update_d;
    logic             busy_q, busy_d;
    logic             phase_end, last_bit;
    logic             abort_hit, abort_pend;

    assign phase_end = (cnt_q == '0);
    assign last_bit  = (bits_q == BITS_ONE);
    assign shifted   = sreg_q << 1;

`ifdef SEQ_GEN_ABORT_EN
    logic pend_q, pend_d;
    logic aborted_q, aborted_d;

    // Abort outside the high phase cuts the frame on the next edge.
    assign abort_hit  = abort && (state_q == S_SETUP || state_q == S_LOW);
    assign abort_pend = pend_q;

    // An abort seen while update is high is remembered until that bit's low
    // phase ends, so update never gets an early falling edge.
    always_comb begin
        pend_d    = pend_q;
        aborted_d = 1'b0;
        if (state_q != S_IDLE && state_d == S_IDLE) begin
            pend_d    = 1'b0;
            aborted_d = !done_d;
        end else if (state_q == S_HIGH && abort) begin
            pend_d = 1'b1;
        end
    end

    // Abort bookkeeping registers.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            pend_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            aborted_q <= aborted_d;
        end
    end

    assign aborted = aborted_q;
`else
    assign abort_hit  = 1'b0;
    assign abort_pend = 1'b0;
`endif

    // State and registered outputs; update/busy are flops so they cannot glitch.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            update_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            update_q <= update_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state: phase sequencing, frame end and abort exits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SETUP;
            S_SETUP: begin
                if (abort_hit)      state_d = S_IDLE;
                else if (phase_end) state_d = S_HIGH;
            end
            S_HIGH:  if (phase_end) state_d = S_LOW;
            S_LOW: begin
                if (abort_hit)                                 state_d = S_IDLE;
                else if (phase_end && (last_bit || abort_pend)) state_d = S_IDLE;
                else if (phase_end)                            state_d = S_SETUP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the upcoming state and registered alongside it.
    always_comb begin
        update_d = (state_d == S_HIGH);
        busy_d   = (state_d != S_IDLE);
    end

    // Datapath: phase counter reload, shift register, bit count and done pulse.
    always_comb begin
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        sreg_d  = sreg_q;
        value_d = value_q;
        done_d  = 1'b0;

        if (state_q != state_d) begin
            case (state_d)
                S_SETUP: cnt_d = SETUP_LD;
                S_HIGH:  cnt_d = HIGH_LD;
                S_LOW:   cnt_d = LOW_LD;
                default: cnt_d = '0;
            endcase
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (state_q == S_IDLE && start) begin
            sreg_d  = data;
            bits_d  = BITS_LD;
            value_d = data[WIDTH-1];
        end else if (state_q == S_LOW && state_d == S_SETUP) begin
            sreg_d  = shifted;
            bits_d  = bits_q - 1'b1;
            value_d = shifted[WIDTH-1];
        end

        if (state_q == S_LOW && phase_end && last_bit && !abort_hit && !abort_pend)
            done_d = 1'b1;
    end

    // Datapath registers.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            bits_q  <= '0;
            sreg_q  <= '0;
            value_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            sreg_q  <= sreg_d;
            value_q <= value_d;
            done_q  <= done_d;
        end
    end

    assign update = update_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign value  = value_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: two instances (WIDTH=4 S1/H2/L2 and
// WIDTH=8 S2/H1/L3), each looped back into a falling-edge receiver.
module tb_sequence_generator;

    localparam int W_A = 4, S_A = 1, H_A = 2, L_A = 2, P_A = S_A + H_A + L_A;
    localparam int W_B = 8, S_B = 2, H_B = 1, L_B = 3, P_B = S_B + H_B + L_B;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0;
    logic [W_A-1:0] data_a = '0;
    logic [W_B-1:0] data_b = '0;
    logic busy_a, done_a, update_a, value_a;
    logic busy_b, done_b, update_b, value_b;
`ifdef SEQ_GEN_ABORT_EN
    logic abort_a = 1'b0;
    logic aborted_a, aborted_b;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sequence_generator #(.WIDTH(W_A), .SETUP_CYCLES(S_A), .HIGH_CYCLES(H_A), .LOW_CYCLES(L_A)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .data(data_a),
`ifdef SEQ_GEN_ABORT_EN
        .abort(abort_a), .aborted(aborted_a),
`endif
        .busy(busy_a), .done(done_a), .update(update_a), .value(value_a));

    sequence_generator #(.WIDTH(W_B), .SETUP_CYCLES(S_B), .HIGH_CYCLES(H_B), .LOW_CYCLES(L_B)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .data(data_b),
`ifdef SEQ_GEN_ABORT_EN
        .abort(1'b0), .aborted(aborted_b),
`endif
        .busy(busy_b), .done(done_b), .update(update_b), .value(value_b));

    // Loop-back receivers: sample value on each falling edge of update.
    logic rx_a_q[$];
    logic rx_b_q[$];
    always @(negedge update_a) if (reset) rx_a_q.push_back(value_a);
    always @(negedge update_b) if (reset) rx_b_q.push_back(value_b);

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    task automatic test_reset();
        #12;
        vectors++;
        if ({busy_a, done_a, update_a, value_a, busy_b, done_b, update_b, value_b} !== 8'b0) begin
            miscompares++;
            $display("FAIL reset_state got %b want 00000000",
                     {busy_a, done_a, update_a, value_a, busy_b, done_b, update_b, value_b});
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    // Sends d on instance A and checks every cycle of the frame, plus the done
    // cycle, against a cycle-index model. Starts from an idle or done cycle.
    task automatic frame_a(input logic [W_A-1:0] d, input bit hold,
                           input logic [W_A-1:0] d_next, input bit poke);
        logic [3:0] got, exp;
        logic [W_A-1:0] rxw;
        int ph, bi;
        rx_a_q.delete();
        start_a = 1'b1;
        data_a  = d;
        for (int k = 0; k <= W_A * P_A; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                if (hold) data_a = d_next;
                else      start_a = 1'b0;
            end
            if (poke && k == 7) begin start_a = 1'b1; data_a = 4'b0110; end
            if (poke && k == 9) start_a = 1'b0;
            if (k < W_A * P_A) begin
                ph  = k % P_A;
                bi  = k / P_A;
                exp = {1'b1, 1'b0, (ph >= S_A && ph < S_A + H_A), d[W_A-1-bi]};
            end else begin
                exp = {1'b0, 1'b1, 1'b0, d[0]};
            end
            got = {busy_a, done_a, update_a, value_a};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL frame_a d=%b k=%0d busy/done/update/value got %b want %b", d, k, got, exp);
            end
        end
        rxw = '0;
        foreach (rx_a_q[i]) rxw = {rxw[W_A-2:0], rx_a_q[i]};
        vectors++;
        if (rx_a_q.size() != W_A || rxw !== d) begin
            miscompares++;
            $display("FAIL rx_a samples got %0d bits %b want %0d bits %b", rx_a_q.size(), rxw, W_A, d);
        end
    endtask

    task automatic test_frame();
        frame_a(4'b1001, 1'b0, 4'b0000, 1'b0);
        for (int n = 0; n < 3; n++) frame_a(4'($urandom), 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic test_ignore_start();
        frame_a(4'b1001, 1'b0, 4'b0000, 1'b1);
        @(posedge clk); #1;
        vectors++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            miscompares++;
            $display("FAIL ignored_start_queued busy/done got %b%b want 00", busy_a, done_a);
        end
    endtask

    task automatic test_back_to_back();
        frame_a(4'b1001, 1'b1, 4'b1100, 1'b0);
        frame_a(4'b1100, 1'b0, 4'b0000, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [W_A-1:0] d;
        d = 4'($urandom);
        start_a = 1'b1;
        data_a  = d;
        for (int k = 0; k <= P_A + S_A; k++) begin
            @(posedge clk); #1;
            if (k == 0) start_a = 1'b0;
        end
        vectors++;
        if (update_a !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_precond update got %b want 1", update_a);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({busy_a, done_a, update_a, value_a} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_mid_async busy/done/update/value got %b want 0000",
                     {busy_a, done_a, update_a, value_a});
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        frame_a(4'($urandom), 1'b0, 4'b0000, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic loop_b(input logic [W_B-1:0] d);
        int nbusy, ncyc;
        logic [W_B-1:0] rxw;
        rx_b_q.delete();
        start_b = 1'b1;
        data_b  = d;
        @(posedge clk); #1;
        start_b = 1'b0;
        nbusy = 0;
        ncyc  = 0;
        while (done_b !== 1'b1 && ncyc < 200) begin
            if (busy_b) nbusy++;
            @(posedge clk); #1;
            ncyc++;
        end
        vectors++;
        if (done_b !== 1'b1 || busy_b !== 1'b0 || nbusy != W_B * P_B) begin
            miscompares++;
            $display("FAIL loop_b_timing done=%b busy=%b busy_cycles got %0d want %0d",
                     done_b, busy_b, nbusy, W_B * P_B);
        end
        rxw = '0;
        foreach (rx_b_q[i]) rxw = {rxw[W_B-2:0], rx_b_q[i]};
        vectors++;
        if (rx_b_q.size() != W_B || rxw !== d) begin
            miscompares++;
            $display("FAIL loop_b_rx got %0d bits %b want %0d bits %b", rx_b_q.size(), rxw, W_B, d);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_loopback();
        loop_b(8'b01101100);
        for (int n = 0; n < 2; n++) loop_b(8'($urandom));
    endtask

`ifdef SEQ_GEN_ABORT_EN
    // Abort raised during cycle kab of a frame: a high-phase abort lets the
    // bit finish, any other phase ends the frame on the next edge.
    task automatic abort_a_at(input int kab);
        logic [W_A-1:0] d;
        logic [4:0] got, exp;
        int ph, fin, nbits;
        d = 4'($urandom);
        ph = kab % P_A;
        fin = (ph >= S_A && ph < S_A + H_A) ? (kab / P_A + 1) * P_A : kab + 1;
        nbits = 0;
        for (int b = 0; b < W_A; b++) if (b * P_A + S_A + H_A < fin) nbits++;
        rx_a_q.delete();
        start_a = 1'b1;
        data_a  = d;
        for (int k = 0; k <= fin + 1; k++) begin
            @(posedge clk); #1;
            if (k == 0) start_a = 1'b0;
            if (k == kab) abort_a = 1'b1;
            if (k == kab + 1) abort_a = 1'b0;
            if (k < fin)
                exp = {1'b1, 1'b0, ((k % P_A) >= S_A && (k % P_A) < S_A + H_A), d[W_A-1-k/P_A], 1'b0};
            else
                exp = {1'b0, 1'b0, 1'b0, d[W_A-1-(fin-1)/P_A], (k == fin)};
            got = {busy_a, done_a, update_a, value_a, aborted_a};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL abort kab=%0d k=%0d busy/done/update/value/aborted got %b want %b",
                         kab, k, got, exp);
            end
        end
        vectors++;
        if (rx_a_q.size() != nbits) begin
            miscompares++;
            $display("FAIL abort_rx_count kab=%0d got %0d want %0d", kab, rx_a_q.size(), nbits);
        end else begin
            foreach (rx_a_q[i]) begin
                vectors++;
                if (rx_a_q[i] !== d[W_A-1-i]) begin
                    miscompares++;
                    $display("FAIL abort_rx_bit %0d got %b want %b", i, rx_a_q[i], d[W_A-1-i]);
                end
            end
        end
    endtask

    task automatic test_abort();
        abort_a_at(S_A);
        abort_a_at(0);
        for (int n = 0; n < 4; n++) abort_a_at(int'($urandom_range(0, W_A * P_A - 1)));
        abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({busy_a, done_a, aborted_a, update_a} !== 4'b0) begin
            miscompares++;
            $display("FAIL abort_idle busy/done/aborted/update got %b want 0000",
                     {busy_a, done_a, aborted_a, update_a});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_loopback();
`ifdef SEQ_GEN_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
